// File: rtl/comm_pkg.sv
// Shared byte/block definitions for the UART <-> AES datapath.
// Used by both the receive buffer and the transmit side.
package comm_pkg;

  localparam int BYTE_W          = 8;
  localparam int BLOCK_W         = 128;
  localparam int BYTES_PER_BLOCK = 16;
  localparam int BYTE_IDX_W      = $clog2(BYTES_PER_BLOCK);

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [BYTE_W-1:0]  byte_t;

  // Append a byte at the LSB end so the first byte received ends up as the MSB.
  function automatic block_t shift_in_byte(input block_t blk, input byte_t b);
    return {blk[BLOCK_W-BYTE_W-1:0], b};
  endfunction

endpackage

// File: rtl/rx_block_buffer_if.sv
// Byte stream in / block stream out bundle of the receive block buffer.
// master = UART receiver plus AES controller side, slave = the buffer.
interface rx_block_buffer_if;
  import comm_pkg::*;

  byte_t                 rx_data;
  logic                  rx_valid;
  logic                  rx_read;
  block_t                pt;
  logic                  rx_empty;
  logic                  rx_full;
  logic                  rx_overflow;
  logic [BYTE_IDX_W-1:0] byte_count;

  modport master (
    output rx_data, rx_valid, rx_read,
    input  pt, rx_empty, rx_full, rx_overflow, byte_count
  );

  modport slave (
    input  rx_data, rx_valid, rx_read,
    output pt, rx_empty, rx_full, rx_overflow, byte_count
  );

endinterface

// File: rtl/rx_block_buffer_fifo.sv
// Generic show-ahead FIFO: head entry is visible on dout, zero when empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module block_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             push_accept,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_ok;

  always_comb begin
    pop_ok      = pop && (count_q != '0);
    push_accept = push && ((count_q != CW'(DEPTH)) || pop_ok);
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push_accept) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_accept && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_accept) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/rx_block_buffer.sv
// Assembles 16 received bytes into a 128-bit block and queues blocks for the
// AES controller; drops blocks on overflow and stale partial blocks on timeout.
module rx_block_buffer
  import comm_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic         clk,
  input logic         reset,
  rx_block_buffer_if.slave bus
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0]     IDLE_RELOAD = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX    = BYTE_IDX_W'(BYTES_PER_BLOCK - 1);

  block_t                asm_q, asm_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  ovf_q, ovf_d;

  logic                  commit;
  block_t                commit_blk;
  logic                  push_accept;
  block_t                fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_count;

  always_comb begin
    commit     = bus.rx_valid && (idx_q == LAST_IDX);
    commit_blk = shift_in_byte(asm_q, bus.rx_data);
    asm_d      = asm_q;
    idx_d      = idx_q;
    idle_d     = idle_q;
    ovf_d      = ovf_q || (commit && !push_accept);
    // A byte arriving on the timeout cycle still counts; the byte wins.
    if (bus.rx_valid) begin
      asm_d  = commit ? '0 : commit_blk;
      idx_d  = idx_q + BYTE_IDX_W'(1);
      idle_d = IDLE_RELOAD;
    end else if (idx_q != '0) begin
      if (idle_q == '0) begin
        asm_d  = '0;
        idx_d  = '0;
        idle_d = IDLE_RELOAD;
      end else begin
        idle_d = idle_q - IDLE_W'(1);
      end
    end else begin
      idle_d = IDLE_RELOAD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_q  <= '0;
      idx_q  <= '0;
      idle_q <= IDLE_RELOAD;
      ovf_q  <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      idx_q  <= idx_d;
      idle_q <= idle_d;
      ovf_q  <= ovf_d;
    end
  end

  block_fifo #(
    .WIDTH (BLOCK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (commit),
    .din         (commit_blk),
    .pop         (bus.rx_read),
    .push_accept (push_accept),
    .dout        (fifo_dout),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .count       (fifo_count)
  );

  occupancy_in_range : assert property (
    @(posedge clk) disable iff (!reset) fifo_count <= CW'(DEPTH)
  );

  assign bus.pt          = fifo_dout;
  assign bus.rx_empty    = fifo_empty;
  assign bus.rx_full     = fifo_full;
  assign bus.rx_overflow = ovf_q;
  assign bus.byte_count  = idx_q;

endmodule

// File: tb/tb_rx_block_buffer.sv
// Directed bench for rx_block_buffer: assembly order, queueing, overflow,
// same-cycle commit/pop, inter-byte timeout, empty reads and async reset.
module tb_rx_block_buffer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  rx_block_buffer_if bus ();

  rx_block_buffer #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [7:0] base);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives n consecutive bytes, returns at a negedge.
  task automatic send_bytes(input logic [7:0] first, input int n, input logic rd_on_last);
    for (int i = 0; i < n; i++) begin
      bus.rx_data  = first + 8'(i);
      bus.rx_valid = 1'b1;
      bus.rx_read  = rd_on_last && (i == n - 1);
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    bus.rx_read  = 1'b0;
  endtask

  task automatic pop();
    bus.rx_read = 1'b1;
    @(negedge clk);
    bus.rx_read = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.rx_read  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_empty", bus.rx_empty, 1);
    chk("rst_full", bus.rx_full, 0);
    chk("rst_ovf", bus.rx_overflow, 0);
    chk("rst_bc", bus.byte_count, 0);
    chk("rst_pt", bus.pt, 0);
    reset = 1'b1;
    @(negedge clk);

    // first block, byte order
    send_bytes(8'h00, 5, 1'b0);
    chk("bc_mid", bus.byte_count, 5);
    chk("empty_mid", bus.rx_empty, 1);
    send_bytes(8'h05, 11, 1'b0);
    chk("blk0_pt", bus.pt, 128'h000102030405060708090a0b0c0d0e0f);
    chk("blk0_empty", bus.rx_empty, 0);
    chk("blk0_bc", bus.byte_count, 0);
    pop();
    chk("pop0_empty", bus.rx_empty, 1);
    chk("pop0_pt", bus.pt, 0);

    // fill to DEPTH, then commit coinciding with a pop
    send_bytes(8'h10, 16, 1'b0);
    send_bytes(8'h20, 16, 1'b0);
    send_bytes(8'h30, 16, 1'b0);
    chk("fill3_full", bus.rx_full, 0);
    send_bytes(8'h40, 16, 1'b0);
    chk("fill4_full", bus.rx_full, 1);
    chk("fill4_pt", bus.pt, mk(8'h10));
    send_bytes(8'h50, 16, 1'b1);
    chk("coinc_ovf", bus.rx_overflow, 0);
    chk("coinc_full", bus.rx_full, 1);
    chk("coinc_pt", bus.pt, mk(8'h20));
    pop();
    chk("coinc_pop1", bus.pt, mk(8'h30));
    pop();
    chk("coinc_pop2", bus.pt, mk(8'h40));
    pop();
    chk("coinc_pop3", bus.pt, mk(8'h50));
    pop();
    chk("coinc_empty", bus.rx_empty, 1);

    // overflow: fifth block dropped
    send_bytes(8'h60, 16, 1'b0);
    send_bytes(8'h70, 16, 1'b0);
    send_bytes(8'h80, 16, 1'b0);
    send_bytes(8'h90, 16, 1'b0);
    chk("ovf_pre", bus.rx_overflow, 0);
    send_bytes(8'hB0, 16, 1'b0);
    chk("ovf_set", bus.rx_overflow, 1);
    chk("ovf_full", bus.rx_full, 1);
    chk("ovf_bc", bus.byte_count, 0);
    chk("ovf_head1", bus.pt, mk(8'h60));
    pop();
    chk("ovf_head2", bus.pt, mk(8'h70));
    chk("ovf_notfull", bus.rx_full, 0);
    pop();
    chk("ovf_head3", bus.pt, mk(8'h80));
    pop();
    chk("ovf_head4", bus.pt, mk(8'h90));
    pop();
    chk("ovf_drain", bus.rx_empty, 1);
    chk("ovf_sticky", bus.rx_overflow, 1);

    // inter-byte timeout
    send_bytes(8'h11, 7, 1'b0);
    chk("to_bc7", bus.byte_count, 7);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("to_before", bus.byte_count, 7);
    @(negedge clk);
    chk("to_after", bus.byte_count, 0);
    send_bytes(8'hA0, 16, 1'b0);
    chk("to_blk", bus.pt, mk(8'hA0));
    chk("to_bc0", bus.byte_count, 0);
    pop();
    chk("to_empty", bus.rx_empty, 1);

    // reads while empty
    pop();
    pop();
    pop();
    chk("underrun_empty", bus.rx_empty, 1);
    chk("underrun_pt", bus.pt, 0);
    chk("underrun_full", bus.rx_full, 0);
    send_bytes(8'hC0, 16, 1'b0);
    chk("underrun_blk", bus.pt, mk(8'hC0));
    pop();
    chk("underrun_after", bus.rx_empty, 1);

    // async reset mid-block with two blocks queued
    send_bytes(8'hD0, 16, 1'b0);
    send_bytes(8'hE0, 16, 1'b0);
    send_bytes(8'h01, 5, 1'b0);
    chk("pre_rst_bc", bus.byte_count, 5);
    chk("pre_rst_pt", bus.pt, mk(8'hD0));
    #2 reset = 1'b0;
    #1;
    chk("arst_empty", bus.rx_empty, 1);
    chk("arst_full", bus.rx_full, 0);
    chk("arst_ovf", bus.rx_overflow, 0);
    chk("arst_bc", bus.byte_count, 0);
    chk("arst_pt", bus.pt, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_bytes(8'hF0, 16, 1'b0);
    chk("post_rst_pt", bus.pt, mk(8'hF0));
    chk("post_rst_bc", bus.byte_count, 0);
    chk("post_rst_full", bus.rx_full, 0);
    pop();
    chk("post_rst_empty", bus.rx_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
